mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Upstream select sequencer for the 4:1 mux stage.
- Drives the S1/S0 select pair of the 4:1 mux and reads back its Y output.
- Sweeps enabled channels in ascending order, holding each select for a settle time plus a programmable dwell time, then captures the mux output into a per-channel sample register.
- Provides a valid/done pulse interface to downstream logic and supports single-sweep or continuous scanning.

Parameters:
DWELL_W, 8, width of the DWELL input and the internal dwell counter.
SETTLE, 1, cycles the select is held before the dwell count starts (0 allowed = no settle phase).

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
EN  input  1  scan enable; level-sensitive.
MASK  input  4  channel enable mask; bit n enables channel n (I0..I3).
DWELL  input  DWELL_W  dwell cycles per channel; 0 is treated as 1.
Y  input  1  mux output fed back from the 4:1 mux.
S0  output  1  select LSB to the mux (registered).
S1  output  1  select MSB to the mux (registered).
SAMPLE  output  4  captured Y per channel; bit n = last sample of channel n.
CH  output  2  channel index of the most recent capture.
VALID  output  1  one-cycle pulse: SAMPLE[CH] updated this cycle.
DONE  output  1  one-cycle pulse: last enabled channel of a sweep captured.
BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - S1,S0=00, SAMPLE=0000, CH=00, VALID=0, DONE=0, BUSY=0, state=IDLE.
  - All counters and latched MASK/DWELL are cleared.
  - Reset asserted mid-sweep aborts immediately; no VALID or DONE is produced on the reset cycle.
- States: IDLE, SETTLE, DWELL.
- IDLE:
  - If EN=1 and MASK!=0 at an edge: latch MASK and DWELL (sweep-constant) and pick the lowest set MASK bit as ch.
  - On that same edge, register S1,S0=ch and enter SETTLE (or DWELL directly if SETTLE=0).
  - If MASK==0, remain in IDLE; no pulses are generated.
  - In IDLE, S1,S0 hold their last value.
- SETTLE: counts SETTLE cycles with the select stable, then goes to DWELL.
- DWELL:
  - Counts max(DWELL_latched,1) cycles.
  - On the edge ending the final dwell cycle: SAMPLE[ch]<=Y, CH<=ch, VALID<=1 for exactly the following cycle. Other SAMPLE bits are unchanged.
  - Then advance to the next higher set bit in the latched mask, update S1,S0 on the same edge, and go to SETTLE.
- End of sweep (no higher bit set):
  - DONE<=1, coincident with the final VALID.
  - If EN=1 on that edge: re-latch MASK/DWELL, wrap to the lowest set bit, and continue. This gives gapless continuous mode.
  - If EN=1 and the new MASK==0, go to IDLE.
  - If EN=0, go to IDLE.
- EN deasserted mid-sweep: the current sweep completes normally, then the block goes to IDLE.
- MASK/DWELL changes mid-sweep are ignored until the next sweep start.
- Timing:
  - Per-channel time = SETTLE + max(DWELL,1) cycles.
  - The first capture edge is SETTLE + max(DWELL,1) edges after the accepting edge.
- Dwell counter: width DWELL_W, no overflow. DWELL=2^DWELL_W-1 is the maximum.
- VALID and DONE never assert in IDLE, and never for a disabled channel.

Test Plan:
1. rst, then EN=1 pulse for 1 cycle, MASK=1111, DWELL=2, SETTLE=1; bench mux model with I0..I3=1,0,1,1 -> S1S0 steps 00,01,10,11 at 3-cycle intervals; VALID at 4 cycles with CH=0,1,2,3; DONE with the 4th VALID, 12 cycles after the accepting edge; SAMPLE=1101; then IDLE, BUSY=0.
2. MASK=1010, DWELL=0, EN held 1 -> only channels 1,3 are visited; each dwell lasts 1 cycle (2-cycle channels); DONE every 4 cycles; sweeps wrap gaplessly; S1S0 never 00 or 10 after the first select.
3. MASK=0000, EN=1 for 20 cycles -> stays IDLE; BUSY, VALID, DONE stay 0; SAMPLE unchanged.
4. Continuous scan with MASK=1111; drop EN after the channel-1 capture -> channels 2,3 are still captured; DONE is asserted; then IDLE; no further VALID.
5. Change MASK 1111->0001 and DWELL 2->5 mid-sweep with EN=1 -> the current sweep uses the old values; the next sweep visits only channel 0 with a 6-cycle period.
6. rst asserted on a capture edge mid-sweep -> the next cycle shows SAMPLE=0000, VALID=0, DONE=0, S1S0=00, BUSY=0; with EN=1 the scan restarts from the lowest enabled channel.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: select sequencer for a 4:1 mux stage.
// Walks the enabled channels in ascending order, holding each select for
// SETTLE cycles plus a dwell time, then captures the fed-back mux output Y
// into a per-channel sample bit. Supports single-sweep and gapless
// continuous scanning.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no sweep active; selects hold their last value
// ST_SETTLE | select just changed, waiting SETTLE cycles for the mux
// ST_DWELL  | counting the dwell; capture Y on the final dwell cycle
module mux_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EN,
  input  logic [3:0]         MASK,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic               Y,
  output logic               S0,
  output logic               S1,
  output logic [3:0]         SAMPLE,
  output logic [1:0]         CH,
  output logic               VALID,
  output logic               DONE,
  output logic               BUSY
);

  // Settle counter holds 0..SETTLE-1; keep at least one bit so SETTLE=0/1 elaborate.
  localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         ch, ch_nxt;
  logic [1:0]         sel, sel_nxt;
  logic [3:0]         mask_lat, mask_nxt;
  logic [DWELL_W-1:0] dwell_lat, dwell_nxt;
  logic [SET_W-1:0]   set_cnt, set_cnt_nxt;
  logic [DWELL_W-1:0] dw_cnt, dw_cnt_nxt;
  logic [3:0]         sample_q, sample_nxt;
  logic [1:0]         ch_q, ch_q_nxt;
  logic               valid_q, valid_nxt;
  logic               done_q, done_nxt;

  logic [3:0]         above;
  logic               has_next;
  logic [1:0]         next_ch;

  logic               enter;
  logic [1:0]         enter_ch;
  logic [DWELL_W-1:0] enter_dwell;

  // Lowest set bit of a channel mask (callers guarantee m != 0).
  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Down-counter load value: DWELL of 0 behaves as a single cycle.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  // Channels strictly above the current one that are still enabled this sweep.
  always_comb begin
    above    = mask_lat & (4'b1110 << ch);
    has_next = |above;
    next_ch  = lowest_bit(above);
  end

  // Next-state, counter and capture logic.
  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch;
    sel_nxt     = sel;
    mask_nxt    = mask_lat;
    dwell_nxt   = dwell_lat;
    set_cnt_nxt = set_cnt;
    dw_cnt_nxt  = dw_cnt;
    sample_nxt  = sample_q;
    ch_q_nxt    = ch_q;
    valid_nxt   = 1'b0;
    done_nxt    = 1'b0;
    enter       = 1'b0;
    enter_ch    = ch;
    enter_dwell = dwell_lat;

    case (state)
      ST_IDLE: begin
        if (EN && (MASK != 4'b0000)) begin
          mask_nxt    = MASK;
          dwell_nxt   = DWELL;
          enter       = 1'b1;
          enter_ch    = lowest_bit(MASK);
          enter_dwell = DWELL;
        end
      end

      ST_SETTLE: begin
        if (set_cnt == '0) begin
          state_nxt  = ST_DWELL;
          dw_cnt_nxt = dwell_load(dwell_lat);
        end else begin
          set_cnt_nxt = set_cnt - SET_W'(1);
        end
      end

      ST_DWELL: begin
        if (dw_cnt != '0) begin
          dw_cnt_nxt = dw_cnt - DWELL_W'(1);
        end else begin
          sample_nxt[ch] = Y;
          ch_q_nxt       = ch;
          valid_nxt      = 1'b1;
          if (has_next) begin
            enter    = 1'b1;
            enter_ch = next_ch;
          end else begin
            done_nxt = 1'b1;
            // Continuous mode: re-latch on the final capture edge so sweeps are gapless.
            if (EN && (MASK != 4'b0000)) begin
              mask_nxt    = MASK;
              dwell_nxt   = DWELL;
              enter       = 1'b1;
              enter_ch    = lowest_bit(MASK);
              enter_dwell = DWELL;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Moving onto a channel: the select changes on this edge and the settle/dwell restarts.
    if (enter) begin
      ch_nxt  = enter_ch;
      sel_nxt = enter_ch;
      if (SETTLE == 0) begin
        state_nxt  = ST_DWELL;
        dw_cnt_nxt = dwell_load(enter_dwell);
      end else begin
        state_nxt   = ST_SETTLE;
        set_cnt_nxt = SET_W'(SETTLE - 1);
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ch        <= 2'd0;
      sel       <= 2'd0;
      mask_lat  <= 4'b0000;
      dwell_lat <= '0;
      set_cnt   <= '0;
      dw_cnt    <= '0;
      sample_q  <= 4'b0000;
      ch_q      <= 2'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      ch        <= ch_nxt;
      sel       <= sel_nxt;
      mask_lat  <= mask_nxt;
      dwell_lat <= dwell_nxt;
      set_cnt   <= set_cnt_nxt;
      dw_cnt    <= dw_cnt_nxt;
      sample_q  <= sample_nxt;
      ch_q      <= ch_q_nxt;
      valid_q   <= valid_nxt;
      done_q    <= done_nxt;
    end
  end

  assign S1     = sel[1];
  assign S0     = sel[0];
  assign SAMPLE = sample_q;
  assign CH     = ch_q;
  assign VALID  = valid_q;
  assign DONE   = done_q;
  assign BUSY   = (state != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scenarios plus a randomized run, all
// compared every cycle against a channel-timing model of the sequencer.
module tb_mux_scan_ctrl;

  localparam int DWELL_W = 8;
  localparam int SETTLE  = 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               EN = 1'b0;
  logic [3:0]         MASK = 4'b0000;
  logic [DWELL_W-1:0] DWELL = '0;
  logic [3:0]         mux_in = 4'b0000;
  logic               Y;
  logic               S0, S1;
  logic [3:0]         SAMPLE;
  logic [1:0]         CH;
  logic               VALID, DONE, BUSY;

  assign Y = mux_in[{S1, S0}];

  mux_scan_ctrl #(.DWELL_W(DWELL_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .EN(EN), .MASK(MASK), .DWELL(DWELL), .Y(Y),
    .S0(S0), .S1(S1), .SAMPLE(SAMPLE), .CH(CH), .VALID(VALID), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int valid_seen = 0;
  bit chk_en = 1'b0;

  // Model: a sweep is a list of enabled channels, each lasting SETTLE+max(DWELL,1) cycles.
  bit         m_busy = 1'b0;
  logic [1:0] m_sel = 2'd0, m_cur = 2'd0, m_ch = 2'd0;
  logic [3:0] m_sample = 4'b0000, m_mask = 4'b0000;
  bit         m_valid = 1'b0, m_done = 1'b0;
  int         m_left = 0, m_period = 0, m_nxt = 0;
  logic       m_y;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic start_sweep();
    m_mask   = MASK;
    m_period = SETTLE + ((DWELL == '0) ? 1 : int'(DWELL));
    for (int c = 3; c >= 0; c--) if (MASK[c]) m_cur = 2'(c);
    m_sel    = m_cur;
    m_left   = m_period;
    m_busy   = 1'b1;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0; m_sel = 2'd0; m_cur = 2'd0; m_ch = 2'd0;
      m_sample = 4'b0000; m_mask = 4'b0000; m_valid = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_y = mux_in[m_sel];
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (!m_busy) begin
        if (EN && MASK != 4'b0000) start_sweep();
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_sample[m_cur] = m_y;
          m_ch    = m_cur;
          m_valid = 1'b1;
          m_nxt   = -1;
          for (int c = 3; c > int'(m_cur); c--) if (m_mask[c]) m_nxt = c;
          if (m_nxt >= 0) begin
            m_cur  = 2'(m_nxt);
            m_sel  = m_cur;
            m_left = m_period;
          end else begin
            m_done = 1'b1;
            if (EN && MASK != 4'b0000) start_sweep();
            else m_busy = 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sel",    {30'd0, S1, S0}, {30'd0, m_sel});
      check("sample", {28'd0, SAMPLE}, {28'd0, m_sample});
      check("ch",     {30'd0, CH},     {30'd0, m_ch});
      check("valid",  {31'd0, VALID},  {31'd0, m_valid});
      check("done",   {31'd0, DONE},   {31'd0, m_done});
      check("busy",   {31'd0, BUSY},   {31'd0, m_busy});
      if (VALID === 1'b1) valid_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Cycles from call until DONE is seen; -1 if it never comes within the limit.
  task automatic wait_done(input int limit, output int dt);
    int start;
    start = cyc;
    dt = -1;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (DONE === 1'b1) begin
        dt = cyc - start;
        break;
      end
    end
  endtask

  task automatic wait_valid_ch(input logic [1:0] target, input int limit, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (VALID === 1'b1 && CH === target) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_idle(input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      if (BUSY === 1'b0) break;
      step(1);
    end
    check(name, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dt, vb, dones;

    rst = 1'b1;
    step(2);
    chk_en = 1'b1;
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    check("reset_sample", {28'd0, SAMPLE}, 32'd0);
    rst = 1'b0;

    // 1: single sweep, all channels, I0..I3 = 1,0,1,1
    mux_in = 4'b1101; MASK = 4'b1111; DWELL = 8'd2; EN = 1'b1;
    vb = valid_seen;
    step(1);
    EN = 1'b0;
    check("t1_busy_start", {31'd0, BUSY}, 32'd1);
    wait_done(40, dt);
    check("t1_done_latency", dt, 32'd12);
    check("t1_sample", {28'd0, SAMPLE}, 32'hD);
    check("t1_valids", valid_seen - vb, 32'd4);
    check("t1_idle", {31'd0, BUSY}, 32'd0);
    step(3);

    // 2: channels 1 and 3, dwell 0, continuous
    MASK = 4'b1010; DWELL = 8'd0; EN = 1'b1; mux_in = 4'($urandom);
    step(1);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("t2_s0_odd", {31'd0, S0}, 32'd1);
      if (DONE === 1'b1) dones++;
    end
    check("t2_done_count", dones, 32'd3);
    check("t2_done_phase", {31'd0, DONE}, 32'd1);
    EN = 1'b0;
    wait_idle(20, "t2_idle");

    // 3: empty mask never starts
    MASK = 4'b0000; EN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("t3_busy", {31'd0, BUSY}, 32'd0);
      check("t3_valid", {31'd0, VALID}, 32'd0);
    end
    EN = 1'b0;

    // 4: drop EN after the channel-1 capture; sweep still finishes
    MASK = 4'b1111; DWELL = 8'd1; EN = 1'b1; mux_in = 4'($urandom);
    wait_valid_ch(2'd1, 30, "t4_ch1_seen");
    EN = 1'b0;
    vb = valid_seen;
    wait_done(20, dt);
    check("t4_done_latency", dt, 32'd4);
    check("t4_valids", valid_seen - vb, 32'd2);
    check("t4_idle", {31'd0, BUSY}, 32'd0);
    vb = valid_seen;
    step(10);
    check("t4_no_more_valid", valid_seen - vb, 32'd0);

    // 5: mid-sweep MASK/DWELL change takes effect on the next sweep
    MASK = 4'b1111; DWELL = 8'd2; EN = 1'b1;
    step(1);
    step(2);
    MASK = 4'b0001; DWELL = 8'd5;
    wait_done(40, dt);
    check("t5_old_sweep", dt, 32'd10);
    wait_done(20, dt);
    check("t5_new_period_a", dt, 32'd6);
    wait_done(20, dt);
    check("t5_new_period_b", dt, 32'd6);
    EN = 1'b0;
    wait_idle(20, "t5_idle");

    // 6: reset on a capture edge
    MASK = 4'b1111; DWELL = 8'd2; EN = 1'b1; mux_in = 4'b1111;
    wait_valid_ch(2'd1, 30, "t6_ch1_seen");
    step(2);
    rst = 1'b1;
    step(1);
    check("t6_sample", {28'd0, SAMPLE}, 32'd0);
    check("t6_valid", {31'd0, VALID}, 32'd0);
    check("t6_done", {31'd0, DONE}, 32'd0);
    check("t6_sel", {30'd0, S1, S0}, 32'd0);
    check("t6_busy", {31'd0, BUSY}, 32'd0);
    rst = 1'b0; MASK = 4'b0110;
    step(1);
    check("t6_restart_sel", {30'd0, S1, S0}, 32'd1);
    check("t6_restart_busy", {31'd0, BUSY}, 32'd1);
    EN = 1'b0;
    wait_idle(30, "t6_idle");

    // Maximum dwell on a single channel
    MASK = 4'b0001; DWELL = 8'd255; EN = 1'b1;
    step(1);
    EN = 1'b0;
    wait_done(300, dt);
    check("max_dwell_latency", dt, 32'd256);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      EN = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) MASK = 4'($urandom);
      if ($urandom_range(0, 15) == 0) DWELL = DWELL_W'($urandom_range(0, 4));
      mux_in = 4'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0; EN = 1'b0;
    wait_idle(100, "rand_idle");
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
